// File: rtl/mem_pkg.sv
// Shared types and control-field bit positions for the MEM stage.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int MEMREAD_BIT  = 3;
  localparam int MEMWRITE_BIT = 2;
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the data memory.
// expired flags the last permitted WAIT cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores over a req/ack memory port, stalls the pipe
// while an access is outstanding and registers the MEM/WB outputs.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_read_data,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_inst2,
  input  logic [3:0]  ex_memcntrl,
  input  logic [1:0]  ex_wbcntrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_inst2,
  output logic [1:0]  wb_cntrl,
  output logic        wb_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  state_t state;
  logic   access;
  logic   is_store;
  logic   misaligned;
  logic   expired;
  logic   pcsrc_unused;

  assign access       = ex_memcntrl[MEMREAD_BIT] | ex_memcntrl[MEMWRITE_BIT];
  assign is_store     = ex_memcntrl[MEMWRITE_BIT];
  assign misaligned   = (ex_result[1:0] != 2'b00);
  // Branch control travels with the instruction but is resolved elsewhere.
  assign pcsrc_unused = ^ex_memcntrl[1:0];

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(expired)
  );

  // Bus signals come straight from the held EX/MEM fields; gating with rst
  // drops stall and the request the moment reset asserts.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (state == WAIT) begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = {ex_result[31:2], 2'b00};
        mem_wdata = ex_read_data;
        stall     = !(mem_ack || expired);
      end else begin
        stall     = access && !misaligned;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wb_read_data <= '0;
      wb_result    <= '0;
      wb_inst2     <= '0;
      wb_cntrl     <= '0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values.
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (!access) begin
            wb_read_data <= '0;
            wb_result    <= ex_result;
            wb_inst2     <= ex_inst2;
            wb_cntrl     <= ex_wbcntrl;
            wb_valid     <= 1'b1;
          end else if (misaligned) begin
            wb_read_data <= '0;
            wb_result    <= ex_result;
            wb_inst2     <= ex_inst2;
            wb_cntrl     <= 2'b00;
            wb_valid     <= 1'b1;
            misalign_err <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            wb_read_data <= is_store ? 32'd0 : mem_rdata;
            wb_result    <= ex_result;
            wb_inst2     <= ex_inst2;
            wb_cntrl     <= ex_wbcntrl;
            wb_valid     <= 1'b1;
            state        <= IDLE;
          end else if (expired) begin
            wb_read_data <= '0;
            wb_result    <= ex_result;
            wb_inst2     <= ex_inst2;
            wb_cntrl     <= 2'b00;
            wb_valid     <= 1'b1;
            bus_err      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: driver pushes expected retirements
// into a scoreboard queue, a negedge monitor pops and compares on wb_valid.
module tb_mem_access_unit;

  localparam int T  = 4;
  localparam int TW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_read_data, ex_result, mem_rdata;
  logic [4:0]  ex_inst2;
  logic [3:0]  ex_memcntrl;
  logic [1:0]  ex_wbcntrl;
  logic        mem_ack;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, wb_read_data, wb_result;
  logic [4:0]  wb_inst2;
  logic [1:0]  wb_cntrl;
  logic        wb_valid, misalign_err, bus_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  inst2;
    logic [1:0]  cntrl;
    logic        mis;
    logic        bus;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_read_data(ex_read_data),
    .ex_result   (ex_result),
    .ex_inst2    (ex_inst2),
    .ex_memcntrl (ex_memcntrl),
    .ex_wbcntrl  (ex_wbcntrl),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wb_read_data(wb_read_data),
    .wb_result   (wb_result),
    .wb_inst2    (wb_inst2),
    .wb_cntrl    (wb_cntrl),
    .wb_valid    (wb_valid),
    .misalign_err(misalign_err),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t nop_exp();
    exp_t e;
    e.result = '0; e.rdata = '0; e.inst2 = '0; e.cntrl = '0;
    e.mis = 1'b0; e.bus = 1'b0; e.chk_rd = 1'b1;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_read_data"}, wb_read_data, 32'd0);
    check({tag, "_wb_result"},    wb_result,    32'd0);
    check({tag, "_wb_inst2"},     32'(wb_inst2),     32'd0);
    check({tag, "_wb_cntrl"},     32'(wb_cntrl),     32'd0);
    check({tag, "_wb_valid"},     32'(wb_valid),     32'd0);
    check({tag, "_misalign_err"}, 32'(misalign_err), 32'd0);
    check({tag, "_bus_err"},      32'(bus_err),      32'd0);
    check({tag, "_mem_req"},      32'(mem_req),      32'd0);
    check({tag, "_mem_we"},       32'(mem_we),       32'd0);
    check({tag, "_stall"},        32'(stall),        32'd0);
    check({tag, "_mem_addr"},     mem_addr,     32'd0);
    check({tag, "_mem_wdata"},    mem_wdata,    32'd0);
  endtask

  // Expected outcome from the instruction's fields and the memory's behaviour:
  // ack_at = WAIT cycle (1-based) on which memory acks; outside 1..T it never does.
  // Called at posedge+1; returns at posedge+1 just after the instruction retires.
  task automatic run_inst(input logic [3:0] mc, input logic [31:0] res, input logic [31:0] wdata,
                          input logic [4:0] rd_reg, input logic [1:0] wbc, input int ack_at,
                          input logic idle_ack, input logic [31:0] rdv);
    exp_t e;
    int   exp_stalls, stalls, waits;
    logic acc, store;
    acc   = mc[3] | mc[2];
    store = mc[2];
    e = nop_exp();
    e.result = res; e.inst2 = rd_reg; e.cntrl = wbc;
    exp_stalls = 0;
    if (acc && res[1:0] != 2'b00) begin
      e.mis = 1'b1; e.cntrl = 2'b00; e.chk_rd = 1'b0;
    end else if (acc && ack_at >= 1 && ack_at <= T) begin
      exp_stalls = ack_at;
      e.rdata    = store ? 32'd0 : rdv;
    end else if (acc) begin
      e.bus = 1'b1; e.cntrl = 2'b00; e.chk_rd = 1'b0;
      exp_stalls = T;
    end
    sb.push_back(e);

    ex_memcntrl = mc; ex_result = res; ex_read_data = wdata;
    ex_inst2 = rd_reg; ex_wbcntrl = wbc;
    mem_ack = idle_ack; mem_rdata = $urandom;
    stalls = 0; waits = 0;
    #1;
    check("mem_req_first_cycle", 32'(mem_req), 32'd0);
    check("mem_addr_first_cycle", mem_addr, 32'd0);
    forever begin
      if (mem_req) begin
        waits++;
        check("mem_addr", mem_addr, {res[31:2], 2'b00});
        check("mem_we", 32'(mem_we), 32'(store));
        check("mem_wdata", mem_wdata, wdata);
        mem_ack   = (waits == ack_at);
        mem_rdata = mem_ack ? rdv : $urandom;
      end
      #1;
      if (!stall) break;
      stalls++;
      if (stalls > T + 2) break;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
  endtask

  // Monitor: one pop per retirement, independent of the driver.
  always @(negedge clk) begin
    if (rst) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_valid_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_result", wb_result, mon_e.result);
          check("wb_inst2", 32'(wb_inst2), 32'(mon_e.inst2));
          check("wb_cntrl", 32'(wb_cntrl), 32'(mon_e.cntrl));
          check("misalign_err", 32'(misalign_err), 32'(mon_e.mis));
          check("bus_err", 32'(bus_err), 32'(mon_e.bus));
          if (mon_e.chk_rd) check("wb_read_data", wb_read_data, mon_e.rdata);
        end
      end else if (misalign_err || bus_err) begin
        check("pulse_without_valid", {30'd0, misalign_err, bus_err}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  mc;
    rst = 1'b0;
    ex_read_data = '0; ex_result = '0; ex_inst2 = '0;
    ex_memcntrl = '0; ex_wbcntrl = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    sb.push_back(nop_exp());
    @(posedge clk); #1;

    // Directed cases
    run_inst(4'b0000, 32'h0000_1234, 32'h0, 5'd7, 2'b10, 0, 1'b0, 32'h0);
    run_inst(4'b1000, 32'h0000_0100, 32'h1111_2222, 5'd5, 2'b11, 3, 1'b0, 32'hDEAD_BEEF);
    run_inst(4'b0100, 32'h0000_0104, 32'hCAFE_F00D, 5'd3, 2'b00, 1, 1'b0, 32'h5555_AAAA);
    run_inst(4'b1000, 32'h0000_0102, 32'h0, 5'd9, 2'b11, 1, 1'b0, 32'h1234_5678);
    run_inst(4'b1000, 32'h0000_0300, 32'h0, 5'd4, 2'b11, 0, 1'b0, 32'h0);
    run_inst(4'b0000, 32'h0000_0011, 32'h0, 5'd1, 2'b10, 0, 1'b0, 32'h0);
    run_inst(4'b0000, 32'h0000_0022, 32'h0, 5'd2, 2'b10, 0, 1'b1, 32'h0);
    run_inst(4'b1100, 32'h0000_0400, 32'h7777_8888, 5'd6, 2'b01, T, 1'b0, 32'h9999_0000);
    run_inst(4'b1000, 32'h0000_0500, 32'h0, 5'd8, 2'b11, T, 1'b1, 32'hABCD_EF01);

    // Reset asserted mid-WAIT: the in-flight load is discarded
    ex_memcntrl = 4'b1000; ex_result = 32'h200; ex_read_data = 32'h0;
    ex_inst2 = 5'd10; ex_wbcntrl = 2'b11; mem_ack = 1'b0;
    @(posedge clk); #2;
    check("rst_pre_mem_req", 32'(mem_req), 32'd1);
    check("rst_pre_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 32'd0);
    check("rst_async_stall", 32'(stall), 32'd0);
    ex_memcntrl = '0; ex_result = '0; ex_inst2 = '0; ex_wbcntrl = '0;
    @(negedge clk); #1;
    check_all_zero("rst_hold");
    rst = 1'b1;
    #1;
    check_all_zero("rst_release");
    sb.push_back(nop_exp());
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      mc = 4'($urandom);
      run_inst(mc, r, $urandom, 5'($urandom), 2'($urandom),
               $urandom_range(1, T + 1), 1'($urandom_range(0, 2) == 0), $urandom);
    end

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
